// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - asynchronous SRAM controller with registered strobes and MMIO peripheral decode
module sram_ctrl #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 2,
    parameter int MMIO_COUNT  = 5
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_be,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic [MMIO_COUNT-1:0] mem_sel,
    output logic                  mem_we,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic [ADDR_W-1:0]     sram_addr,
    output logic [DATA_W-1:0]     sram_dq_out,
    output logic                  sram_dq_oe,
    input  logic [DATA_W-1:0]     sram_dq_in,
    output logic                  sram_ce_n,
    output logic                  sram_oe_n,
    output logic                  sram_we_n,
    output logic [DATA_W/8-1:0]   sram_be_n
);
    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(WAIT_CYCLES + 2);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(WAIT_CYCLES);
    localparam logic [ADDR_W-1:0] MMIO_LIM = ADDR_W'(MMIO_COUNT);

    typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, MMIO} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    write_q, write_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [DATA_W-1:0]       wdata_q, wdata_d;
    logic [BE_W-1:0]         be_q, be_d;
    logic                    req_ready_q, req_ready_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]       rsp_rdata_q, rsp_rdata_d;
    logic [MMIO_COUNT-1:0]   mem_sel_q, mem_sel_d;
    logic                    mem_we_q, mem_we_d;
    logic [DATA_W-1:0]       mem_wdata_q, mem_wdata_d;
    logic [ADDR_W-1:0]       sram_addr_q, sram_addr_d;
    logic [DATA_W-1:0]       dq_out_q, dq_out_d;
    logic                    dq_oe_q, dq_oe_d;
    logic                    ce_n_q, ce_n_d;
    logic                    oe_n_q, oe_n_d;
    logic                    we_n_q, we_n_d;
    logic [BE_W-1:0]         be_n_q, be_n_d;

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    if (req_addr < MMIO_LIM) state_d = MMIO;
                    else if (req_write)      state_d = WR_SETUP;
                    else                     state_d = RD;
                end
            end
            RD:       if (cnt_q == '0) state_d = IDLE;
            WR_SETUP: state_d = WR_PULSE;
            WR_PULSE: if (cnt_q == '0) state_d = WR_HOLD;
            WR_HOLD:  state_d = IDLE;
            MMIO:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase

        // Counter reloads on every state change, so RD/WR_PULSE last WAIT_CYCLES+1 cycles.
        if (state_d != state_q)  cnt_d = CNT_LOAD;
        else if (cnt_q != '0)    cnt_d = cnt_q - CNT_W'(1);
        else                     cnt_d = cnt_q;

        req_ready_d = (state_d == IDLE);
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        mem_sel_d   = '0;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        sram_addr_d = sram_addr_q;
        dq_out_d    = dq_out_q;
        dq_oe_d     = 1'b0;
        ce_n_d      = 1'b1;
        oe_n_d      = 1'b1;
        we_n_d      = 1'b1;
        be_n_d      = '1;

        if (state_q == RD && state_d == IDLE) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = sram_dq_in;
        end
        if (state_q == MMIO && !write_q) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = mem_rdata;
        end

        // Pin values are computed from the upcoming state so each strobe is a clean flop output.
        case (state_d)
            RD: begin
                sram_addr_d = addr_d;
                ce_n_d      = 1'b0;
                oe_n_d      = 1'b0;
                be_n_d      = '0;
            end
            WR_SETUP, WR_PULSE, WR_HOLD: begin
                sram_addr_d = addr_d;
                ce_n_d      = 1'b0;
                dq_oe_d     = 1'b1;
                dq_out_d    = wdata_d;
                be_n_d      = ~be_d;
                if (state_d == WR_PULSE && be_d != '0) we_n_d = 1'b0;
            end
            MMIO: begin
                for (int i = 0; i < MMIO_COUNT; i++) mem_sel_d[i] = (addr_d == ADDR_W'(i));
                mem_we_d    = write_d;
                mem_wdata_d = wdata_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            mem_sel_q   <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            sram_addr_q <= '0;
            dq_out_q    <= '0;
            dq_oe_q     <= 1'b0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            be_n_q      <= '1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            mem_sel_q   <= mem_sel_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            sram_addr_q <= sram_addr_d;
            dq_out_q    <= dq_out_d;
            dq_oe_q     <= dq_oe_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            be_n_q      <= be_n_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign mem_sel     = mem_sel_q;
    assign mem_we      = mem_we_q;
    assign mem_wdata   = mem_wdata_q;
    assign sram_addr   = sram_addr_q;
    assign sram_dq_out = dq_out_q;
    assign sram_dq_oe  = dq_oe_q;
    assign sram_ce_n   = ce_n_q;
    assign sram_oe_n   = oe_n_q;
    assign sram_we_n   = we_n_q;
    assign sram_be_n   = be_n_q;
endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
Parametrised external asynchronous-SRAM controller with memory-mapped I/O decode. It sits between the CPU data path and the off-chip SRAM pins. It replaces the combinational clock-phase strobing with a registered request/response handshake, programmable wait states, per-byte write enables and a bidirectional-bus turnaround guarantee. The lowest MMIO_COUNT addresses route to on-chip peripherals through a one-hot select instead of reaching the SRAM.

Parameters:
ADDR_W, 16, request and SRAM address width
DATA_W, 16, data width; must be a multiple of 8
WAIT_CYCLES, 2, extra access cycles beyond one; the strobe is held low for WAIT_CYCLES+1 cycles
MMIO_COUNT, 5, addresses 0..MMIO_COUNT-1 decode to peripherals (stack, userstack, uart, gpio, gpiodir order)

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  controller can accept; high only in IDLE
req_write  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  word address
req_wdata  in  DATA_W  write data
req_be  in  DATA_W/8  byte enables for writes (bit i = byte i)
rsp_valid  out  1  one-cycle pulse; rsp_rdata valid (reads only)
rsp_rdata  out  DATA_W  registered read data
mem_sel  out  MMIO_COUNT  one-hot peripheral select
mem_we  out  1  peripheral write strobe
mem_wdata  out  DATA_W  peripheral write data
mem_rdata  in  DATA_W  peripheral read data
sram_addr  out  ADDR_W  SRAM address
sram_dq_out  out  DATA_W  SRAM data to pins
sram_dq_oe  out  1  1 = FPGA drives the DQ pins
sram_dq_in  in  DATA_W  SRAM data from pins
sram_ce_n, sram_oe_n, sram_we_n  out  1 each  active-low SRAM strobes
sram_be_n  out  DATA_W/8  active-low byte lane enables (UB/LB for 16-bit)

Behaviour:
- Reset (async, immediate): state IDLE; req_ready=1; rsp_valid=0; rsp_rdata=0; mem_sel=0; mem_we=0; mem_wdata=0; sram_addr=0; sram_dq_out=0; sram_dq_oe=0; sram_ce_n=sram_oe_n=sram_we_n=1; sram_be_n all 1.
- Reset mid-transaction: strobes deassert at once. The transaction is dropped and no rsp_valid is issued.
- All pin and peripheral outputs are registered. No output depends combinationally on CLK level.
- Accept when req_valid && req_ready in IDLE (cycle 0). Address, write data and be are latched. Inputs are ignored until the next IDLE.
- States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, MMIO.
- Routing: req_addr < MMIO_COUNT goes to MMIO. Otherwise a read goes to RD and a write goes to WR_SETUP.
- RD: lasts cycles 1..WAIT_CYCLES+1 with ce_n=0, oe_n=0, be_n all 0, dq_oe=0. sram_dq_in is sampled at the last RD edge. rsp_valid=1 in cycle WAIT_CYCLES+2 (back in IDLE).
- WR_SETUP (1 cycle): ce_n=0, dq_oe=1, dq_out=data, be_n=~be, we_n=1.
- WR_PULSE (WAIT_CYCLES+1 cycles): we_n=0, all else held.
- WR_HOLD (1 cycle): we_n=1, data and address held, dq_oe=1.
- Return to IDLE after WR_HOLD; no rsp_valid for writes.
- Write with req_be=0: full timing is run, but we_n stays 1.
- MMIO (1 cycle): mem_sel[addr]=1; mem_we=req_write; mem_wdata=data. SRAM strobes stay inactive. On a read, mem_rdata is sampled at the end of that cycle and rsp_valid pulses the next cycle.
- Turnaround: at least one IDLE cycle separates any two accepted transactions. dq_oe is 0 in IDLE, so oe_n=0 never overlaps dq_oe=1.
- A wait counter of width clog2(WAIT_CYCLES+2) reloads on each state entry. WAIT_CYCLES=0 gives single-cycle RD and WR_PULSE.
- sram_addr holds its last value in IDLE. ce_n=1 in IDLE.

Test Plan:
- Reset, then read 0x0100 with SRAM model returning 0xBEEF, WAIT_CYCLES=2 -> oe_n low cycles 1-3, rsp_valid in cycle 4 with rsp_rdata=0xBEEF, req_ready low cycles 1-3.
- Write 0x0200 <- 0x1234, be=2'b11 -> WR_SETUP cycle 1 (dq_oe=1, we_n=1), we_n low cycles 2-4, hold cycle 5, IDLE cycle 6. Read-back returns 0x1234.
- Write 0x0200 <- 0xAA55, be=2'b01 over existing 0x1234 -> be_n=2'b10 during pulse. Read-back returns 0x1255.
- Read addr 2 (uart) with mem_rdata=0x0041 -> mem_sel=5'b00100 for one cycle, SRAM ce_n stays 1, rsp_rdata=0x0041. Write addr 4 -> mem_sel=5'b10000 with mem_we=1.
- Back-to-back write then read with req_valid held -> one IDLE cycle between them. Assert dq_oe && !oe_n never true.
- Assert RST during WR_PULSE -> we_n=1, dq_oe=0, ce_n=1 without waiting for a clock edge. No rsp_valid. req_ready=1 after release.
